spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_ss_decoder.sv | 24 ++
 rtl/spi_master_ctrl.sv | 124 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI master control slice.
// Used by spi_master_ctrl and spi_ss_decoder.
package spi_pkg;

    localparam int SPI_REG_WIDTH_DEF  = 8;
    localparam int SPI_NUM_SLAVES_DEF = 4;
    localparam int SPI_GUARD_DEF      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_ss_decoder.sv
// 1-of-N active-low slave-select decoder.
// All lines stay high unless enable is asserted.
module spi_ss_decoder
    import spi_pkg::*;
#(
    parameter int NUM_SLAVES = SPI_NUM_SLAVES_DEF
) (
    input  logic [$clog2(NUM_SLAVES)-1:0] index,
    input  logic                          enable,
    output logic [NUM_SLAVES-1:0]         ss_n
);

    localparam int SEL_W = $clog2(NUM_SLAVES);

    always_comb begin
        ss_n = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (enable && (index == SEL_W'(i))) begin
                ss_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master control FSM: load strobe, shift enable and chip selects.
// Define SPI_CS_GUARD_EN to add CS setup/hold guard states.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int REG_WIDTH    = SPI_REG_WIDTH_DEF,
    parameter int NUM_SLAVES   = SPI_NUM_SLAVES_DEF,
    parameter int GUARD_CYCLES = SPI_GUARD_DEF
) (
    input  logic                          sclk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(NUM_SLAVES)-1:0] slave_sel,
    input  logic [REG_WIDTH-1:0]          tx_data,
    output logic [REG_WIDTH-1:0]          data_out,
    output logic                          load_en,
    output logic                          shift_en,
    output logic [NUM_SLAVES-1:0]         ss_n,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = $clog2(REG_WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(REG_WIDTH - 1);
    localparam logic [SEL_W:0]   SLV_LIM  = (SEL_W + 1)'(NUM_SLAVES);

    spi_ctrl_state_t r_state;
    spi_ctrl_state_t w_next;

    logic [SEL_W-1:0]     r_sel;
    logic [REG_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_err;
    logic                 w_start_ok;
    logic                 w_bit_last;
    logic                 w_ss_en;

    assign w_start_ok = start && ({1'b0, slave_sel} < SLV_LIM);
    assign w_bit_last = (r_bit_cnt == BIT_LAST);

`ifdef SPI_CS_GUARD_EN
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    logic [3:0] r_guard_cnt;
    logic       w_guard_last;

    assign w_guard_last = (r_guard_cnt == 4'd0);

    // Reloaded on entry to SETUP and HOLD, counts down to zero
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_guard_cnt <= 4'd0;
        end else if ((r_state == ST_LOAD) ||
                     ((r_state == ST_SHIFT) && w_bit_last)) begin
            r_guard_cnt <= GUARD_LAST;
        end else if (((r_state == ST_SETUP) || (r_state == ST_HOLD)) &&
                     !w_guard_last) begin
            r_guard_cnt <= r_guard_cnt - 4'd1;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_ok) w_next = ST_LOAD;
`ifdef SPI_CS_GUARD_EN
            ST_LOAD:  w_next = ST_SETUP;
            ST_SETUP: if (w_guard_last) w_next = ST_SHIFT;
            ST_SHIFT: if (w_bit_last) w_next = ST_HOLD;
            ST_HOLD:  if (w_guard_last) w_next = ST_DONE;
`else
            ST_LOAD:  w_next = ST_SHIFT;
            ST_SETUP: w_next = ST_IDLE;
            ST_SHIFT: if (w_bit_last) w_next = ST_DONE;
            ST_HOLD:  w_next = ST_IDLE;
`endif
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_data    <= '0;
            r_bit_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == ST_IDLE) && start && !w_start_ok;
            // Word and target are frozen at acceptance
            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_sel  <= slave_sel;
                r_data <= tx_data;
            end
            if (r_state == ST_SHIFT) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    assign w_ss_en = (r_state == ST_LOAD) || (r_state == ST_SETUP) ||
                     (r_state == ST_SHIFT) || (r_state == ST_HOLD);

    assign data_out = r_data;
    assign load_en  = (r_state == ST_LOAD);
    assign shift_en = (r_state == ST_SHIFT);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;

    spi_ss_decoder #(
        .NUM_SLAVES(NUM_SLAVES)
    ) u_ss_dec (
        .index (r_sel),
        .enable(w_ss_en),
        .ss_n  (ss_n)
    );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl (default widths, plus a
// NUM_SLAVES=3 instance for rejected selects); honours SPI_CS_GUARD_EN.
module tb_spi_master_ctrl;

    localparam int W = 8;
`ifdef SPI_CS_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif
    localparam int LAT = 2 + 2 * G + W;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [3:0] ss;
        int         gap;
    } exp_t;

    logic       sclk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] slave_sel;
    logic [7:0] tx_data;
    logic [7:0] data_out;
    logic       load_en, shift_en, busy, done, err;
    logic [3:0] ss_n;

    logic       start2;
    logic [1:0] sel2;
    logic [7:0] tx2;
    logic [7:0] data_out2;
    logic       load2, shift2, busy2, done2, err2;
    logic [2:0] ss2;

    always #5 sclk = ~sclk;

    spi_master_ctrl #(
        .REG_WIDTH(8), .NUM_SLAVES(4), .GUARD_CYCLES(2)
    ) dut (
        .sclk(sclk), .rst(rst), .start(start), .slave_sel(slave_sel),
        .tx_data(tx_data), .data_out(data_out), .load_en(load_en),
        .shift_en(shift_en), .ss_n(ss_n), .busy(busy), .done(done),
        .err(err)
    );

    spi_master_ctrl #(
        .REG_WIDTH(8), .NUM_SLAVES(3), .GUARD_CYCLES(2)
    ) dut2 (
        .sclk(sclk), .rst(rst), .start(start2), .slave_sel(sel2),
        .tx_data(tx2), .data_out(data_out2), .load_en(load2),
        .shift_en(shift2), .ss_n(ss2), .busy(busy2), .done(done2),
        .err(err2)
    );

    exp_t q[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   inv_bad  = 0;

    function automatic void chk(bit ok, string name, longint act,
                                longint expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endfunction

    // Monitor for the main instance
    int         ncyc = 0;
    int         load_cyc = 0, first_sh = -1, last_sh = -1;
    int         shifts = 0, ss_low = 0, prev_done = -100;
    bit         in_x = 0, stable = 1;
    logic [7:0] ld_data = '0;
    logic [3:0] ss_pat = '1;
    exp_t       m_e;

    always @(negedge sclk) begin
        ncyc++;
        if (load_en && shift_en) inv_bad++;
        if ($countones(~ss_n) > 1) inv_bad++;
        if ((!busy || done) && ss_n != 4'hF) inv_bad++;
        if (!busy) begin
            in_x = 0;
        end else if (load_en) begin
            in_x = 1; load_cyc = ncyc; ld_data = data_out;
            ss_pat = ss_n; shifts = 0; ss_low = 0; stable = 1;
            first_sh = -1; last_sh = -1;
        end
        if (in_x) begin
            if (ss_n != 4'hF) begin
                ss_low++;
                if (ss_n != ss_pat) stable = 0;
            end
            if (data_out != ld_data) stable = 0;
            if (shift_en) begin
                if (first_sh < 0) first_sh = ncyc;
                last_sh = ncyc;
                shifts++;
            end
        end
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk(0, "unexpected_done", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk(!m_e.is_err, "done_kind", 1, m_e.is_err);
                chk(ncyc - load_cyc == LAT - 1, "latency",
                    ncyc - load_cyc + 1, LAT);
                chk(ld_data == m_e.data, "load_data", ld_data, m_e.data);
                chk(ss_pat == m_e.ss, "ss_select", ss_pat, m_e.ss);
                chk(ss_low == LAT - 1, "ss_low_cycles", ss_low, LAT - 1);
                chk(shifts == W, "shift_cycles", shifts, W);
                chk(last_sh - first_sh + 1 == W, "shift_contig",
                    last_sh - first_sh + 1, W);
                chk(first_sh - load_cyc == 1 + G, "load_to_shift",
                    first_sh - load_cyc, 1 + G);
                chk(stable, "held_stable", stable, 1);
                chk(ss_n == 4'hF, "ss_at_done", ss_n, 4'hF);
                if (m_e.gap >= 0)
                    chk(load_cyc - prev_done == m_e.gap, "b2b_gap",
                        load_cyc - prev_done, m_e.gap);
            end
            in_x = 0;
            prev_done = ncyc;
        end
        if (err) begin
            if (q.size() == 0) chk(0, "unexpected_err", 1, 0);
            else begin
                m_e = q.pop_front();
                chk(m_e.is_err, "err_kind", 1, m_e.is_err);
            end
        end
    end

    // Monitor for the reject-only instance
    always @(negedge sclk) begin
        if (busy2) inv_bad++;
        if (ss2 != 3'b111) inv_bad++;
        if (done2) chk(0, "unexpected_done2", 1, 0);
        if (err2) begin
            if (q2.size() == 0) chk(0, "unexpected_err2", 1, 0);
            else begin
                m_e = q2.pop_front();
                chk(m_e.is_err, "err2_kind", 1, m_e.is_err);
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_idle(string name);
        int k;
        for (k = 0; k < 200; k++) begin
            if (q.size() == 0 && q2.size() == 0 && !busy &&
                !err && !err2) break;
            tick();
        end
        if (k == 200) chk(0, {name, "_timeout"}, k, 200);
        tick();
        tick();
    endtask

    initial begin
        int n;
        int d0;
        rst = 1; start = 0; slave_sel = 0; tx_data = 0;
        start2 = 0; sel2 = 0; tx2 = 0;
        tick();
        tick();
        chk(ss_n == 4'hF, "rst_ss_n", ss_n, 4'hF);
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(err == 0, "rst_err", err, 0);
        chk(load_en == 0, "rst_load_en", load_en, 0);
        chk(shift_en == 0, "rst_shift_en", shift_en, 0);
        chk(data_out == 8'h00, "rst_data_out", data_out, 0);
        chk(ss2 == 3'b111, "rst_ss2", ss2, 3'b111);
        rst = 0;
        tick();

        // Basic transfer, plus a start while busy that must be dropped
        q.push_back('{0, 8'hA5, 4'b1011, -1});
        slave_sel = 2; tx_data = 8'hA5; start = 1;
        tick();
        start = 0; slave_sel = 0;
        repeat (4) tick();
        start = 1; slave_sel = 3; tx_data = 8'h77;
        tick();
        start = 0;
        wait_idle("xfer_a5");

        // Out-of-range select on the 3-slave instance
        q2.push_back('{1, 8'h00, 4'hF, -1});
        sel2 = 3; tx2 = 8'h55; start2 = 1;
        tick();
        start2 = 0;
        wait_idle("err_reject");

        // Reset in the 4th SHIFT cycle
        slave_sel = 1; tx_data = 8'h5A; start = 1;
        tick();
        start = 0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (shift_en) n++;
            if (n == 4) break;
            tick();
        end
        chk(n == 4, "reach_shift4", n, 4);
        d0 = done_cnt;
        rst = 1;
        tick();
        chk(busy == 0, "midrst_busy", busy, 0);
        chk(ss_n == 4'hF, "midrst_ss_n", ss_n, 4'hF);
        chk(shift_en == 0, "midrst_shift_en", shift_en, 0);
        rst = 0;
        repeat (20) tick();
        chk(done_cnt == d0, "midrst_no_done", done_cnt - d0, 0);

        // Start held high: back-to-back with one IDLE cycle between
        q.push_back('{0, 8'hC3, 4'b1110, -1});
        q.push_back('{0, 8'hC3, 4'b1110, 2});
        slave_sel = 0; tx_data = 8'hC3; start = 1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) n++;
            if (n == 2) break;
        end
        start = 0;
        chk(n == 2, "b2b_two_done", n, 2);
        wait_idle("b2b");

        // Inputs changed after acceptance
        q.push_back('{0, 8'h3C, 4'b0111, -1});
        slave_sel = 3; tx_data = 8'h3C; start = 1;
        tick();
        start = 0; tx_data = 8'hFF; slave_sel = 1;
        repeat (3) tick();
        tx_data = 8'h00;
        wait_idle("tx_change");

        // Reset wins over start
        rst = 1; slave_sel = 2; tx_data = 8'h99; start = 1;
        tick();
        chk(busy == 0, "rst_over_start", busy, 0);
        rst = 0; start = 0;
        tick();
        chk(busy == 0, "rst_start_no_xfer", busy, 0);

        q.push_back('{0, 8'h81, 4'b1101, -1});
        slave_sel = 1; tx_data = 8'h81; start = 1;
        tick();
        start = 0;
        wait_idle("xfer_81");

        repeat (3) tick();
        chk(q.size() == 0, "sb_drain", q.size(), 0);
        chk(q2.size() == 0, "sb2_drain", q2.size(), 0);
        chk(inv_bad == 0, "invariants", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
